pipe_hazard_sched: RTL
======================

# pipe_hazard_sched

Pipeline hazard scheduler for the ECNURVCORE 5-stage pipeline; replaces the pass-through jump/hold controller. It arbitrates all stall sources (data-bus wait, multi-cycle divider, load-use, instruction-bus wait) into one per-stage hold code. It also sequences jump redirects, including redirects that arrive while fetch is stalled. It sits between EX/MEM and the PC/IF/ID/EX pipeline registers.

## Interface
- DIV_CYCLES, 32, divider latency in cycles, ≥2
- ADDR_W, 32, width of `BUS_ADDR_MEM`
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- jmp_en_i  in  1  taken jump/branch resolved in EX
- jmp_to_i  in  ADDR_W  jump target
- load_bypass_i  in  1  load-use hazard detected in ID (`LOAD_BYPASS_EN`)
- div_start_i  in  1  divide instruction entered EX this cycle
- if_busy_i  in  1  instruction bus not ready
- mem_busy_i  in  1  data bus not ready for MEM-stage access
- jmp_en_o  out  1  redirect PC this cycle
- jmp_to_o  out  ADDR_W  redirect target
- flush_o  out  1  bubble IF/ID and ID/EX
- hold_code_o  out  3  `BUS_HOLD_CODE`, freeze level
- div_busy_o  out  1  divider counting

## Operation
- Hold code freezes all registers up to and including the named one:
  - NOPE=0: no freeze.
  - PC=1: PC only.
  - ID=2: PC and IF/ID.
  - EX=3: PC, IF/ID and ID/EX.
- Stall priority, highest first:
  - mem_busy_i → EX.
  - div_busy_o → EX.
  - load_bypass_i → ID.
  - if_busy_i, or pending redirect → PC.
  - Otherwise NOPE.
- FSM states: IDLE, DIV, PEND.
- IDLE + div_start_i → DIV.
  - Counter loads DIV_CYCLES-1.
  - div_busy_o=1 from the next cycle.
- DIV: counter decrements each cycle, but not while mem_busy_i=1.
  - At 0, return to IDLE.
  - div_busy_o is high for exactly DIV_CYCLES-1 cycles when there is no mem stall.
- Jump with EX hold level active (mem_busy_i or div_busy_o): ignored. The jump instruction stays in EX and jmp_en_i stays asserted.
- Jump, no EX hold, if_busy_i=0: same-cycle redirect.
  - jmp_en_o=1, jmp_to_o=jmp_to_i, flush_o=1.
  - Load-use hold is overridden, so hold_code_o=NOPE.
- Jump, no EX hold, if_busy_i=1:
  - flush_o=1 this cycle.
  - Target latched into pend_addr; go to PEND.
  - jmp_en_o=0.
- PEND:
  - hold_code_o=PC and flush_o=1 (IF/ID bubble each cycle).
  - In the first cycle with if_busy_i=0: jmp_en_o=1, jmp_to_o=pend_addr, return to IDLE.
  - A new jmp_en_i in PEND is impossible (pipeline flushed) and is ignored.
- div_start_i together with jmp_en_i is illegal (mutually exclusive decode); the bench asserts it never happens.
- div_start_i outside IDLE is ignored.
- jmp_to_o=0 whenever jmp_en_o=0.

## Timing
- All outputs are combinational from inputs plus registered state (FSM, counter, pend_addr). No added latency on the IDLE redirect.
- Reset while rst_n=0, applied at the clk edge:
  - State IDLE, counter 0, pend_addr 0.
  - Outputs forced combinationally to idle: jmp_en_o=0, jmp_to_o=0, flush_o=0, hold_code_o=NOPE, div_busy_o=0.
- Reset mid-DIV or mid-PEND abandons the operation; no redirect is issued afterwards.
- Counter width is $clog2(DIV_CYCLES). It never wraps; decrement stops at 0.

## Structure
- `define.v`:
  - `BUS_HOLD_CODE` widened to [2:0].
  - `HOLD_CODE_NOPE`/`_PC`/`_ID`/`_EX` values.
  - FSM state encodings `SCHED_IDLE`/`SCHED_DIV`/`SCHED_PEND`.
- One sub-module, `div_timer`: loadable down-counter with enable and zero flag. Everything else is inline.

## Test plan
- Reset: rst_n=0 for 2 cycles with jmp_en_i=1, mem_busy_i=1 → all outputs idle. After release, hold_code_o=EX.
- Simple jump: jmp_en_i=1, jmp_to_i=0x8000_0040, load_bypass_i=1 → same cycle jmp_en_o=1, jmp_to_o=0x8000_0040, flush_o=1, hold_code_o=NOPE.
- Divider: DIV_CYCLES=4, div_start_i pulse → div_busy_o=1 and hold_code_o=EX for 3 cycles, then NOPE. With mem_busy_i held 2 cycles mid-count → busy extended to 5 cycles.
- Pending redirect: if_busy_i=1 for 3 cycles, jmp_en_i=1 in cycle 0 to 0x100 → flush_o=1 for cycles 0–3, hold_code_o=PC for cycles 0–2. jmp_en_o=1 with 0x100 only in cycle 3.
- Priority: mem_busy_i, load_bypass_i and if_busy_i all high → EX. Drop mem_busy_i → ID. Drop load_bypass_i → PC.
- Reset in PEND: rst_n=0 for one cycle, then if_busy_i=0 → jmp_en_o stays 0.

Source files
------------

// File: rtl/pipe_hazard_sched_pkg.sv
// pipe_hazard_sched_pkg: hold codes and scheduler state encodings shared by the hazard scheduler.
package pipe_hazard_sched_pkg;
  typedef enum logic [2:0] {
    HOLD_CODE_NOPE = 3'd0,
    HOLD_CODE_PC   = 3'd1,
    HOLD_CODE_ID   = 3'd2,
    HOLD_CODE_EX   = 3'd3
  } hold_code_e;
  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_DIV  = 2'd1,
    SCHED_PEND = 2'd2
  } sched_state_e;
endpackage

// File: rtl/pipe_hazard_sched_div_timer.sv
// div_timer: loadable down-counter with enable, saturating at zero; flags zero and one-left.
module div_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  end
  assign zero = cnt == '0;
  assign last = cnt == W'(1);
endmodule

// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: arbitrates pipeline stalls into one hold code and sequences jump redirects.
module pipe_hazard_sched
  import pipe_hazard_sched_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jmp_en_i,
  input  logic [ADDR_W-1:0] jmp_to_i,
  input  logic              load_bypass_i,
  input  logic              div_start_i,
  input  logic              if_busy_i,
  input  logic              mem_busy_i,
  output logic              jmp_en_o,
  output logic [ADDR_W-1:0] jmp_to_o,
  output logic              flush_o,
  output logic [2:0]        hold_code_o,
  output logic              div_busy_o
);
  localparam int CW = $clog2(DIV_CYCLES);
  sched_state_e      state;
  logic [ADDR_W-1:0] pend_addr;
  logic              idle, pend, ex_hold, take_jmp, cnt_zero, cnt_last;
  assign idle       = state == SCHED_IDLE;
  assign pend       = rst_n && state == SCHED_PEND;
  assign div_busy_o = rst_n && state == SCHED_DIV;
  assign ex_hold    = mem_busy_i || div_busy_o;
  assign take_jmp   = rst_n && idle && jmp_en_i && !ex_hold;
  assign jmp_en_o   = (take_jmp || pend) && !if_busy_i;
  assign jmp_to_o   = !jmp_en_o ? '0 : pend ? pend_addr : jmp_to_i;
  assign flush_o    = take_jmp || pend;
  // An issuing redirect discards the younger instructions, so a load-use stall no longer matters.
  always_comb
    hold_code_o = !rst_n                   ? HOLD_CODE_NOPE :
                  ex_hold                  ? HOLD_CODE_EX   :
                  jmp_en_o                 ? HOLD_CODE_NOPE :
                  load_bypass_i            ? HOLD_CODE_ID   :
                  (if_busy_i || pend)      ? HOLD_CODE_PC   : HOLD_CODE_NOPE;
  div_timer #(.W(CW)) u_div_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (idle && div_start_i),
    .load_val (CW'(DIV_CYCLES - 1)),
    .en       (state == SCHED_DIV && !mem_busy_i),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );
  // Leave DIV on the edge where the counter reaches zero, giving DIV_CYCLES-1 busy cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SCHED_IDLE;
      pend_addr <= '0;
    end else begin
      case (state)
        SCHED_IDLE:
          if (div_start_i) state <= SCHED_DIV;
          else if (take_jmp && if_busy_i) begin
            state     <= SCHED_PEND;
            pend_addr <= jmp_to_i;
          end
        SCHED_DIV:  if (cnt_zero || (!mem_busy_i && cnt_last)) state <= SCHED_IDLE;
        SCHED_PEND: if (!if_busy_i) state <= SCHED_IDLE;
        default:    state <= SCHED_IDLE;
      endcase
    end
  end
endmodule
